// File: rtl/rt_imp_hls_deadlock_pkg.sv
// ---------------------------------------------------------------------------
// rt_imp_hls_deadlock_pkg
// Shared definitions for the HLS deadlock detect/report slice: the report
// FSM state encoding and the default sizing constants used by the report
// unit and its detect-unit neighbours.
// ---------------------------------------------------------------------------
package rt_imp_hls_deadlock_pkg;

   // Report FSM states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ORIGIN = 3'd1,
      ST_TRACE  = 3'd2,
      ST_REPORT = 3'd3,
      ST_HOLD   = 3'd4
   } dl_state_e;

   // Default sizing of the report unit
   localparam int DL_PROC_NUM_DEF = 4;
   localparam int DL_PROC_NUM_MAX = 32;
   localparam int DL_TIMEOUT_DEF  = 255;
   localparam int DL_CNT_W_DEF    = 8;

endpackage

// File: rtl/rt_imp_hls_prio_onehot.sv
// ---------------------------------------------------------------------------
// rt_imp_hls_prio_onehot
// Lowest-index priority selector: returns a one-hot vector holding only the
// least-significant set bit of the request, or zero when nothing requests.
// Ports:
//   req_i  in  W  request vector
//   gnt_o  out W  one-hot grant (lowest set bit of req_i)
// ---------------------------------------------------------------------------
module rt_imp_hls_prio_onehot #(
   parameter int W = 4
) (
   input  logic [W-1:0] req_i,
   output logic [W-1:0] gnt_o
);

   // Two's-complement isolates the lowest set bit: req & -req.
   assign gnt_o = req_i & (~req_i + W'(1));

endmodule

// File: rtl/rt_imp_hls_deadlock_report_unit.sv
// ---------------------------------------------------------------------------
// rt_imp_hls_deadlock_report_unit
// Collects deadlock detections from the per-process detect units, elects one
// origin process, traces the token ring to build the set of processes on the
// deadlock cycle, and holds the report until the host acknowledges it.
// Ports:
//   clock             in   rising-edge clock
//   reset             in   asynchronous, active-low reset
//   dl_detect_vec     in   per-process dl_detect_out
//   token_ret_vec     in   per-process token-present indication
//   report_ack        in   host acknowledge, releases a held report
//   origin_vec        out  one-hot origin strobe (ORIGIN state only)
//   dl_detect_global  out  global deadlock flag to all detect units
//   token_clear       out  one-cycle token-ring clear (REPORT state only)
//   deadlock_valid    out  report available
//   deadlock_proc     out  bitmap of processes on the deadlock cycle
//   deadlock_timeout  out  report was forced by the trace timeout
//   trace_cnt         out  TRACE cycles consumed by current/last report
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module rt_imp_hls_deadlock_report_unit
   import rt_imp_hls_deadlock_pkg::*;
#(
   parameter int PROC_NUM = DL_PROC_NUM_DEF,
   parameter int TIMEOUT  = DL_TIMEOUT_DEF,
   parameter int CNT_W    = DL_CNT_W_DEF
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [PROC_NUM-1:0] dl_detect_vec,
   input  logic [PROC_NUM-1:0] token_ret_vec,
   input  logic                report_ack,
   output logic [PROC_NUM-1:0] origin_vec,
   output logic                dl_detect_global,
   output logic                token_clear,
   output logic                deadlock_valid,
   output logic [PROC_NUM-1:0] deadlock_proc,
   output logic                deadlock_timeout,
   output logic [CNT_W-1:0]    trace_cnt
);

   localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);

   dl_state_e           state_q, state_d;
   logic [PROC_NUM-1:0] sel_q, sel_d;
   logic [PROC_NUM-1:0] origin_q, origin_d;
   logic                glob_q, glob_d;
   logic                clear_q, clear_d;
   logic                valid_q, valid_d;
   logic [PROC_NUM-1:0] proc_q, proc_d;
   logic                tmo_q, tmo_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PROC_NUM-1:0] first_det;

   rt_imp_hls_prio_onehot #(
      .W (PROC_NUM)
   ) u_prio (
      .req_i (dl_detect_vec),
      .gnt_o (first_det)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         sel_q    <= '0;
         origin_q <= '0;
         glob_q   <= 1'b0;
         clear_q  <= 1'b0;
         valid_q  <= 1'b0;
         proc_q   <= '0;
         tmo_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         origin_q <= origin_d;
         glob_q   <= glob_d;
         clear_q  <= clear_d;
         valid_q  <= valid_d;
         proc_q   <= proc_d;
         tmo_q    <= tmo_d;
         cnt_q    <= cnt_d;
      end
   end

   // Output registers are loaded with the values belonging to the state being
   // entered, so every output is valid in the same cycle as its state.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      origin_d = '0;
      glob_d   = glob_q;
      clear_d  = 1'b0;
      valid_d  = valid_q;
      proc_d   = proc_q;
      tmo_d    = tmo_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (|dl_detect_vec) begin
               state_d  = ST_ORIGIN;
               sel_d    = first_det;
               origin_d = first_det;
               proc_d   = first_det;
               cnt_d    = '0;
               tmo_d    = 1'b0;
               glob_d   = 1'b1;
            end
         end
         ST_ORIGIN: begin
            state_d = ST_TRACE;
         end
         ST_TRACE: begin
            proc_d = proc_q | token_ret_vec;
            if (cnt_q != TMO_C) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            // Token back at the origin wins over a timeout in the same cycle.
            if (|(token_ret_vec & sel_q)) begin
               state_d = ST_REPORT;
               tmo_d   = 1'b0;
               clear_d = 1'b1;
               valid_d = 1'b1;
            end else if (cnt_q == TMO_C) begin
               state_d = ST_REPORT;
               tmo_d   = 1'b1;
               clear_d = 1'b1;
               valid_d = 1'b1;
            end
         end
         ST_REPORT: begin
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (report_ack) begin
               state_d = ST_IDLE;
               sel_d   = '0;
               glob_d  = 1'b0;
               valid_d = 1'b0;
               proc_d  = '0;
               tmo_d   = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign origin_vec       = origin_q;
   assign dl_detect_global = glob_q;
   assign token_clear      = clear_q;
   assign deadlock_valid   = valid_q;
   assign deadlock_proc    = proc_q;
   assign deadlock_timeout = tmo_q;
   assign trace_cnt        = cnt_q;

endmodule
